// File: rtl/psw_pkg.sv
// Shared types and width helpers for the password sequence verifier.
package psw_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTER = 3'd1,
        S_CHECK = 3'd2,
        S_LOCK  = 3'd3,
        S_PASS  = 3'd4,
        S_DEAD  = 3'd5
    } state_t;

    // Index width never collapses to zero, even for a single-digit password.
    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

    function automatic int try_width(input int max_tries);
        return $clog2(max_tries + 1);
    endfunction

    localparam int DEF_DIGITS    = 4;
    localparam int DEF_MAX_TRIES = 3;
    localparam int DIGIT_IDX_W   = idx_width(DEF_DIGITS);
    localparam int TRY_W         = try_width(DEF_MAX_TRIES);

endpackage

// File: rtl/psw_edge_det.sv
// Single-flop rising-edge detector; a held level produces exactly one pulse.
module psw_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev <= 1'b0;
        else      prev <= din;
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/psw_sequence_verifier.sv
// Multi-digit password entry and check with limited tries, lockout and timer penalty.
module psw_sequence_verifier
    import psw_pkg::*;
#(
    parameter int SW_W      = 7,
    parameter int DIGITS    = 4,
    parameter int MAX_TRIES = 3,
    parameter int LOCK_CYC  = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_input,
    input  logic [SW_W-1:0]                    sw,
    input  logic [DIGITS*SW_W-1:0]             psw,
    input  logic                               btn_confirm,
    input  logic                               btn_clear,
    output logic [SW_W-1:0]                    ld,
    output logic [idx_width(DIGITS)-1:0]       digit_idx,
    output logic [try_width(MAX_TRIES)-1:0]    tries_left,
    output logic                               locked,
    output logic                               penalty,
    output logic                               success,
    output logic                               boom,
    output state_t                             dbg_state
);

    localparam int IW = idx_width(DIGITS);
    localparam int TW = try_width(MAX_TRIES);
    localparam int LW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

    localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);
    localparam logic [TW-1:0] TRIES_INIT = TW'(MAX_TRIES);
    localparam logic [TW-1:0] TRIES_ONE  = TW'(1);
    localparam logic [LW-1:0] LOCK_LAST  = LW'((LOCK_CYC > 0) ? LOCK_CYC - 1 : 0);

    state_t          state, state_nx;
    logic [IW-1:0]   idx_nx;
    logic [TW-1:0]   tries_nx;
    logic [LW-1:0]   lock_cnt, lcnt_nx;
    logic [SW_W-1:0] ld_nx;
    logic [SW_W-1:0] cur_digit;
    logic            mism, mism_nx;
    logic            succ_nx, boom_nx;
    logic            confirm_rise, clear_rise;

    psw_edge_det u_confirm_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_confirm),
        .rise (confirm_rise)
    );

    psw_edge_det u_clear_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_clear),
        .rise (clear_rise)
    );

    // Expected digit for the current position; out-of-range index reads as zero.
    always_comb begin
        cur_digit = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (digit_idx == IW'(k)) cur_digit = psw[k*SW_W +: SW_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            ld         <= '0;
            digit_idx  <= '0;
            tries_left <= TRIES_INIT;
            lock_cnt   <= '0;
            mism       <= 1'b0;
            success    <= 1'b0;
            boom       <= 1'b0;
        end else begin
            state      <= state_nx;
            ld         <= ld_nx;
            digit_idx  <= idx_nx;
            tries_left <= tries_nx;
            lock_cnt   <= lcnt_nx;
            mism       <= mism_nx;
            success    <= succ_nx;
            boom       <= boom_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ld_nx    = ld;
        idx_nx   = digit_idx;
        tries_nx = tries_left;
        lcnt_nx  = lock_cnt;
        mism_nx  = mism;
        succ_nx  = success;
        boom_nx  = boom;
        penalty  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_input) state_nx = S_ENTER;
            end

            S_ENTER: begin
                ld_nx = sw;
                // Dropping start outranks both buttons; clear outranks confirm.
                if (!start_input) begin
                    state_nx = S_IDLE;
                    idx_nx   = '0;
                    mism_nx  = 1'b0;
                end else if (clear_rise) begin
                    idx_nx  = '0;
                    mism_nx = 1'b0;
                end else if (confirm_rise) begin
                    mism_nx = mism | (sw != cur_digit);
                    if (digit_idx == LAST_IDX) state_nx = S_CHECK;
                    else                       idx_nx   = digit_idx + 1'b1;
                end
            end

            S_CHECK: begin
                if (!mism) begin
                    state_nx = S_PASS;
                    succ_nx  = 1'b1;
                end else begin
                    if (tries_left != '0) tries_nx = tries_left - 1'b1;
                    if (tries_left <= TRIES_ONE) begin
                        state_nx = S_DEAD;
                        boom_nx  = 1'b1;
                    end else begin
                        penalty  = 1'b1;
                        idx_nx   = '0;
                        mism_nx  = 1'b0;
                        lcnt_nx  = '0;
                        state_nx = (LOCK_CYC == 0) ? S_ENTER : S_LOCK;
                    end
                end
            end

            S_LOCK: begin
                if (!start_input) begin
                    state_nx = S_IDLE;
                    idx_nx   = '0;
                    mism_nx  = 1'b0;
                end else if (lock_cnt == LOCK_LAST) begin
                    state_nx = S_ENTER;
                end else begin
                    lcnt_nx = lock_cnt + 1'b1;
                end
            end

            S_PASS, S_DEAD: begin
            end

            default: state_nx = S_IDLE;
        endcase
    end

    assign locked    = (state == S_LOCK);
    assign dbg_state = state;

endmodule
